led_breathe: RTL and testbench



---
 rtl/led_breathe_pkg.sv | 18 +
 rtl/led_pwm_cmp.sv | 37 +++
 rtl/led_breathe.sv | 181 ++++++++++++++++++
 tb/tb_led_breathe.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/led_breathe_pkg.sv
// led_breathe_pkg: shared types and helpers for the LED breathing stage.
// Holds the brightness ramp state encoding and the MAX-level helper.
package led_breathe_pkg;

    // Brightness ramp phases, in the order the ramp visits them.
    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } state_t;

    // Largest brightness / PWM count value for a given counter width.
    function automatic int unsigned max_level(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_pwm_cmp.sv
// led_pwm_cmp: one LED's PWM comparator with mask and phase inversion.
// The output is registered so the LED pin sees a clean flop output, one
// cycle after the pwm_cnt value it was compared against.
module led_pwm_cmp
    import led_breathe_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mask,
    input  logic                phase_inv,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] level_lat,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_level(PWM_BITS));

    logic [PWM_BITS-1:0] eff;

    // Complementary LEDs breathe in anti-phase with the others.
    always_comb begin
        eff = phase_inv ? (MAX - level_lat) : level_lat;
    end

    // Registered drive; disabled or masked LEDs are forced dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= en & mask & (pwm_cnt < eff);
        end
    end

endmodule

// File: rtl/led_breathe.sv
// led_breathe: PWM "breathing" driver for the board LED bank.
// Prescaler -> PWM counter -> step divider -> brightness ramp FSM, with the
// brightness latched only at PWM period boundaries so the duty never
// changes mid-period. state_o exposes the ramp FSM for debug.
// Optional build macro LED_BREATHE_GAMMA_EN: latch a square-law corrected
// brightness, (level*level) >> PWM_BITS, instead of the linear level.
module led_breathe
    import led_breathe_pkg::*;
#(
    parameter int N_LEDS     = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 16,
    parameter int STEP_DIV   = 4,
    parameter int HOLD_STEPS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_LEDS-1:0]   mask,
    input  logic [N_LEDS-1:0]   phase_inv,
    output logic [N_LEDS-1:0]   leds,
    output logic [PWM_BITS-1:0] level_o,
    output state_t              state_o
);

    localparam int PS_W = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
    localparam int SD_W = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
    localparam int HD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PWM_BITS-1:0] MAX     = PWM_BITS'(max_level(PWM_BITS));
    localparam logic [PWM_BITS-1:0] MAX_M1  = PWM_BITS'(max_level(PWM_BITS) - 1);
    localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [SD_W-1:0]     SD_LAST = SD_W'(STEP_DIV - 1);
    localparam logic [HD_W-1:0]     HD_LAST = HD_W'(HOLD_STEPS - 1);

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SD_W-1:0]     step_cnt;
    logic [HD_W-1:0]     hold_cnt, hold_nxt;
    logic [PWM_BITS-1:0] level, level_nxt;
    logic [PWM_BITS-1:0] level_lat, lat_val;
    state_t              state, state_nxt;
    logic                tick, period_end, step;

    assign tick       = en & (prescaler == PS_LAST);
    assign period_end = tick & (pwm_cnt == MAX);
    assign step       = period_end & (step_cnt == SD_LAST);

    // Prescaler: divides clk down to PWM ticks; holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PS_W'(1);
        end
    end

    // PWM counter: free-wrapping, one count per tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + ONE;
        end
    end

    // Step divider: one brightness step every STEP_DIV PWM periods.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (period_end) begin
            step_cnt <= (step_cnt == SD_LAST) ? '0 : step_cnt + SD_W'(1);
        end
    end

    // Ramp FSM register: state, brightness and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RISE;
            level    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Ramp FSM next state: only moves on a brightness step.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        hold_nxt  = hold_cnt;
        if (step) begin
            case (state)
                RISE: begin
                    if (level == MAX_M1) begin
                        level_nxt = MAX;
                        state_nxt = HOLD_HI;
                        hold_nxt  = '0;
                    end else begin
                        level_nxt = level + ONE;
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt == HD_LAST) begin
                        state_nxt = FALL;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + HD_W'(1);
                    end
                end
                FALL: begin
                    level_nxt = level - ONE;
                    if (level == ONE) begin
                        state_nxt = HOLD_LO;
                        hold_nxt  = '0;
                    end
                end
                HOLD_LO: begin
                    if (hold_cnt == HD_LAST) begin
                        state_nxt = RISE;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + HD_W'(1);
                    end
                end
                default: begin
                    state_nxt = RISE;
                end
            endcase
        end
    end

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;

    // Square-law brightness for a perceptually smoother ramp.
    always_comb begin
        level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
        lat_val  = level_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    // Linear brightness.
    always_comb begin
        lat_val = level;
    end
`endif

    // Brightness latch: updated only at period ends so duty is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_lat <= '0;
        end else if (period_end) begin
            level_lat <= lat_val;
        end
    end

    assign level_o = level_lat;
    assign state_o = state;

    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_led
            led_pwm_cmp #(
                .PWM_BITS(PWM_BITS)
            ) u_cmp (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .mask     (mask[gi]),
                .phase_inv(phase_inv[gi]),
                .pwm_cnt  (pwm_cnt),
                .level_lat(level_lat),
                .led      (leds[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_breathe.sv
// tb_led_breathe: directed bench for led_breathe with a small configuration
// (PRESCALE=1, PWM_BITS=3, STEP_DIV=1, HOLD_STEPS=2, N_LEDS=2): one PWM
// period is 8 clocks and every period end is a brightness step.
module tb_led_breathe;
    import led_breathe_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mask;
    logic [1:0] phase_inv;
    logic [1:0] leds;
    logic [2:0] level_o;
    state_t     state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Latched brightness expected after the k-th period end (index 0 = reset).
    logic [2:0] exp_lvl [0:21];
    state_t     exp_st  [0:21];

    led_breathe #(
        .N_LEDS    (2),
        .PWM_BITS  (3),
        .PRESCALE  (1),
        .STEP_DIV  (1),
        .HOLD_STEPS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mask     (mask),
        .phase_inv(phase_inv),
        .leds     (leds),
        .level_o  (level_o),
        .state_o  (state_o)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    // Run one PWM period; bit j of each pattern is the LED after edge j+1.
    task automatic run_period(output logic [7:0] p0, output logic [7:0] p1);
        for (int j = 0; j < 8; j++) begin
            step_edge();
            p0[j] = leds[0];
            p1[j] = leds[1];
        end
    endtask

    // Expected per-period LED pattern for an effective level e.
    function automatic logic [7:0] duty_pat(input int e);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < e) r[j] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        logic [7:0] p0, p1, e0, e1;
        int lv, eff0, eff1;

        exp_lvl = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7,
                    3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
        exp_st  = '{RISE, RISE, RISE, RISE, RISE, RISE, RISE, HOLD_HI, HOLD_HI,
                    FALL, FALL, FALL, FALL, FALL, FALL, FALL, HOLD_LO, HOLD_LO,
                    RISE, RISE, RISE, RISE};

        rst       = 1'b1;
        en        = 1'b0;
        mask      = 2'b00;
        phase_inv = 2'b00;
        repeat (3) step_edge();
        check("reset_leds",  32'(leds),    32'd0);
        check("reset_level", 32'(level_o), 32'd0);
        check("reset_state", 32'(state_o), 32'(RISE));

        rst  = 1'b0;
        en   = 1'b1;
        mask = 2'b11;

        for (int k = 1; k <= 21; k++) begin
            if (k == 4) begin
                phase_inv = 2'b10; mask = 2'b11;
            end else if (k == 6) begin
                phase_inv = 2'b10; mask = 2'b01;
            end else begin
                phase_inv = 2'b00; mask = 2'b11;
            end
            lv   = int'(exp_lvl[k-1]);
            eff0 = phase_inv[0] ? 7 - lv : lv;
            eff1 = phase_inv[1] ? 7 - lv : lv;
            e0   = mask[0] ? duty_pat(eff0) : 8'h00;
            e1   = mask[1] ? duty_pat(eff1) : 8'h00;

            if (k == 7) begin
                // Freeze mid-period at pwm_cnt = 4 with brightness 5.
                for (int j = 0; j < 4; j++) begin
                    step_edge();
                    check("pre_freeze_led0", 32'(leds[0]), 32'd1);
                end
                en = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    step_edge();
                    check("freeze_leds",  32'(leds),    32'd0);
                    check("freeze_level", 32'(level_o), 32'd5);
                end
                en = 1'b1;
                step_edge();
                check("resume_pwm4_led0", 32'(leds[0]), 32'd1);
                step_edge();
                check("resume_pwm5_led0", 32'(leds[0]), 32'd0);
                step_edge();
                check("resume_no_early_end", 32'(level_o), 32'd5);
                step_edge();
            end else begin
                run_period(p0, p1);
                check($sformatf("duty_led0_p%0d", k), 32'(p0), 32'(e0));
                check($sformatf("duty_led1_p%0d", k), 32'(p1), 32'(e1));
                if (k == 4) begin
                    check("phase_led0_lvl2", 32'(p0), 32'h03);
                    check("phase_led1_inv5", 32'(p1), 32'h1f);
                end
                if (k == 5) check("duty_lvl3_led0", 32'(p0), 32'h07);
                if (k == 6) check("mask_led1_off", 32'(p1), 32'h00);
            end
            check($sformatf("level_p%0d", k), 32'(level_o), 32'(exp_lvl[k]));
            check($sformatf("state_p%0d", k), 32'(state_o), 32'(exp_st[k]));
        end

        // Mid-run asynchronous reset, checked before any further edge.
        step_edge();
        check("pre_rst_led0", 32'(leds[0]), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_leds",  32'(leds),    32'd0);
        check("async_rst_level", 32'(level_o), 32'd0);
        check("async_rst_state", 32'(state_o), 32'(RISE));
        step_edge();
        rst = 1'b0;
        run_period(p0, p1);
        check("post_rst_p1_led0",  32'(p0),      32'h00);
        check("post_rst_p1_level", 32'(level_o), 32'd0);
        run_period(p0, p1);
        check("post_rst_p2_level", 32'(level_o), 32'd1);
        check("post_rst_p2_state", 32'(state_o), 32'(RISE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
